// File: rtl/instr_encoder.sv
// Encodes R-type and addi requests into 32-bit words. Legal words enter a 2-entry FIFO.
// Latency is 1 cycle from an accepted request to the FIFO head. Backpressure is count<2.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] addr_o,
  input  logic        flush_i,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  logic [31:0] r_mem [0:1];
  logic        r_head;
  logic [1:0]  r_count;
  logic [31:0] r_addr;
  logic        r_err;
  logic [7:0]  r_err_cnt;

  logic        w_is_rtype;
  logic        w_is_addi;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_bad;
  logic        w_tail;
  logic [31:0] w_word;

  assign w_is_rtype = RegDst_i & ~ALUSrc_i & RegWrite_i & (ALUOp_i == 2'b00);
  assign w_is_addi  = ~RegDst_i & ALUSrc_i & RegWrite_i & (ALUOp_i == 2'b01);
  assign w_word     = w_is_rtype ? {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i}
                                 : {6'b001000, rs_i, rt_i, imm_i};

  // ready_o comes only from registered occupancy, so instr_ready_i cannot reach it.
  assign ready_o  = (r_count < 2'd2);
  assign w_accept = valid_i & ready_o & ~flush_i;
  assign w_push   = w_accept & (w_is_rtype | w_is_addi);
  assign w_bad    = w_accept & ~(w_is_rtype | w_is_addi);
  assign w_pop    = (r_count != 2'd0) & instr_ready_i & ~flush_i;
  assign w_tail   = r_head ^ r_count[0];

  assign instr_valid_o = (r_count != 2'd0);
  assign instr_o       = (r_count != 2'd0) ? r_mem[r_head] : 32'h0;
  assign addr_o        = r_addr;
  assign err_o         = r_err;
  assign err_cnt_o     = r_err_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem[0]  <= 32'h0;
      r_mem[1]  <= 32'h0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
      r_addr    <= 32'h0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else if (flush_i) begin
      r_count <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[w_tail] <= w_word;
      end
      if (w_pop) begin
        r_head <= ~r_head;
        r_addr <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_err <= w_bad;
      if (w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule
